// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - fetch/data request ports and shared SRAM bus of sram_arbiter
interface sram_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_addr_ok;
    logic        i_data_ok;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_wr;
    logic [3:0]  d_wstrb;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [31:0] d_rdata;

    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    // arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_wstrb, d_addr, d_wdata, sram_rdata,
        output i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata
    );

    // core and SRAM side
    modport master (
        output i_req, i_addr, d_req, d_wr, d_wstrb, d_addr, d_wdata, sram_rdata,
        input  i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - single-port SRAM shared by fetch and data ports, in-order fixed-latency responses
// SRAM_ARB_FAIR_EN enables the fetch starvation counter; otherwise data always beats fetch.
module sram_arbiter #(
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic           clk,
    input  logic           reset,
    sram_arbiter_if.slave  bus
);
    localparam int LAST = RD_LAT - 1;

    logic fetch_prio;
    logic grant_i;
    logic grant_d;

    // reset gates the grant so addr_ok stays low even with requests pending
    assign grant_i = !reset && bus.i_req && (!bus.d_req || fetch_prio);
    assign grant_d = !reset && bus.d_req && !grant_i;

`ifdef SRAM_ARB_FAIR_EN
    logic [3:0] starve_q;
    logic [3:0] starve_d;

    assign fetch_prio = (starve_q == 4'(STARVE_MAX));

    always_comb begin
        starve_d = starve_q;
        if (grant_i) begin
            starve_d = 4'd0;
        end else if (bus.i_req && grant_d && starve_q != 4'(STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign fetch_prio = 1'b0;
`endif

    always_comb begin
        bus.i_addr_ok  = grant_i;
        bus.d_addr_ok  = grant_d;
        bus.sram_en    = grant_i || grant_d;
        bus.sram_we    = (grant_d && bus.d_wr) ? bus.d_wstrb : 4'b0000;
        bus.sram_addr  = grant_i ? bus.i_addr : (grant_d ? bus.d_addr : 32'd0);
        bus.sram_wdata = grant_d ? bus.d_wdata : 32'd0;
    end

    // Tag pipeline: one slot per cycle of SRAM latency; owner bit 1 = fetch.
    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] vld_d;
    logic [RD_LAT-1:0] own_q;
    logic [RD_LAT-1:0] own_d;

    always_comb begin
        vld_d    = '0;
        own_d    = '0;
        vld_d[0] = grant_i || grant_d;
        own_d[0] = grant_i;
        for (int k = 1; k < RD_LAT; k++) begin
            vld_d[k] = vld_q[k-1];
            own_d[k] = own_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            own_q <= '0;
        end else begin
            vld_q <= vld_d;
            own_q <= own_d;
        end
    end

    logic resp_vld;
    assign resp_vld = vld_q[LAST] && !reset;

    always_comb begin
        bus.i_data_ok = resp_vld && own_q[LAST];
        bus.d_data_ok = resp_vld && !own_q[LAST];
        bus.i_rdata   = bus.i_data_ok ? bus.sram_rdata : 32'd0;
        bus.d_rdata   = bus.d_data_ok ? bus.sram_rdata : 32'd0;
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed and randomized scoreboard bench for sram_arbiter
module tb_sram_arbiter;
    localparam int RD_LAT     = 3;
    localparam int STARVE_MAX = 3;
`ifdef SRAM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sram_arbiter_if bus ();

    sram_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {b, ~b, 8'hA5, b ^ 8'h3C};
    endfunction

    // SRAM model: read word appears on sram_rdata RD_LAT cycles after sram_en
    logic [31:0] sram_mem [256];
    logic [31:0] rd_pipe  [RD_LAT];
    logic [31:0] ref_mem  [256];

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = init_word(i);
            ref_mem[i]  = init_word(i);
        end
    end

    always @(posedge clk) begin
        rd_pipe[0] <= bus.sram_en ? sram_mem[bus.sram_addr[9:2]] : 32'hDEAD_BEEF;
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
        if (bus.sram_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.sram_we[b]) sram_mem[bus.sram_addr[9:2]][8*b +: 8] = bus.sram_wdata[8*b +: 8];
        end
    end
    assign bus.sram_rdata = rd_pipe[RD_LAT-1];

    logic [136:0] all_out;
    assign all_out = {bus.i_addr_ok, bus.i_data_ok, bus.i_rdata, bus.d_addr_ok, bus.d_data_ok,
                      bus.d_rdata, bus.sram_en, bus.sram_we, bus.sram_addr, bus.sram_wdata};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [3:0] ds, input logic [31:0] da, input logic [31:0] dd);
        bus.i_req   = ir;
        bus.i_addr  = ia;
        bus.d_req   = dr;
        bus.d_wr    = dw;
        bus.d_wstrb = ds;
        bus.d_addr  = da;
        bus.d_wdata = dd;
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic apply_reset();
        step();
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
        idle();
    endtask

    task automatic test_reset();
        for (int t = 0; t < 2; t++) begin
            step();
            reset = 1'b1;
            drive(1'b1, 32'h1c00_0000, 1'b1, 1'b1, 4'hF, 32'h100, 32'h1234_5678);
            n_cmp++;
            if (all_out !== '0) begin
                n_err++;
                $display("FAIL reset_outputs t=%0d got %h exp 0", t, all_out);
            end
        end
        step();
        reset = 1'b0;
        idle();
        n_cmp++;
        if (all_out !== '0) begin
            n_err++;
            $display("FAIL post_reset_idle got %h exp 0", all_out);
        end
    endtask

    task automatic test_single_fetch();
        step();
        drive(1'b1, 32'h1c00_0000, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        n_cmp++;
        if ({bus.i_addr_ok, bus.d_addr_ok, bus.sram_en, bus.sram_we, bus.sram_addr, bus.sram_wdata}
            !== {1'b1, 1'b0, 1'b1, 4'b0000, 32'h1c00_0000, 32'd0}) begin
            n_err++;
            $display("FAIL fetch_grant got %b%b%b we=%b a=%h wd=%h", bus.i_addr_ok, bus.d_addr_ok,
                     bus.sram_en, bus.sram_we, bus.sram_addr, bus.sram_wdata);
        end
        for (int k = 1; k <= RD_LAT; k++) begin
            step();
            idle();
            n_cmp++;
            if ({bus.i_data_ok, bus.d_data_ok, bus.i_rdata} !==
                {(k == RD_LAT), 1'b0, (k == RD_LAT) ? init_word(0) : 32'd0}) begin
                n_err++;
                $display("FAIL fetch_resp k=%0d got ok=%b%b rd=%h exp rd=%h", k, bus.i_data_ok,
                         bus.d_data_ok, bus.i_rdata, init_word(0));
            end
        end
    endtask

    task automatic test_store_load();
        for (int t = 0; t <= RD_LAT + 2; t++) begin
            step();
            case (t)
                0: drive(1'b0, 32'd0, 1'b1, 1'b1, 4'b1111, 32'h100, 32'h1122_3344);
                1: drive(1'b0, 32'd0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hAABB_CCDD);
                2: drive(1'b0, 32'd0, 1'b1, 1'b0, 4'b1111, 32'h100, 32'hFFFF_FFFF);
                default: idle();
            endcase
            if (t == 1) begin
                n_cmp++;
                if ({bus.d_addr_ok, bus.sram_en, bus.sram_we, bus.sram_addr, bus.sram_wdata}
                    !== {1'b1, 1'b1, 4'b0011, 32'h100, 32'hAABB_CCDD}) begin
                    n_err++;
                    $display("FAIL partial_store we=%b a=%h wd=%h exp we=0011", bus.sram_we,
                             bus.sram_addr, bus.sram_wdata);
                end
            end
            if (t == 2) begin
                n_cmp++;
                if ({bus.d_addr_ok, bus.sram_en, bus.sram_we} !== {1'b1, 1'b1, 4'b0000}) begin
                    n_err++;
                    $display("FAIL load_grant got ok=%b en=%b we=%b exp 1 1 0000", bus.d_addr_ok,
                             bus.sram_en, bus.sram_we);
                end
            end
            n_cmp++;
            if ({bus.i_data_ok, bus.d_data_ok} !== {1'b0, (t >= RD_LAT && t <= RD_LAT + 2)}) begin
                n_err++;
                $display("FAIL store_load_dok t=%0d got %b%b", t, bus.i_data_ok, bus.d_data_ok);
            end
            if (t == RD_LAT + 2) begin
                n_cmp++;
                if (bus.d_rdata !== 32'h1122_CCDD) begin
                    n_err++;
                    $display("FAIL load_after_store got %h exp 1122ccdd", bus.d_rdata);
                end
            end
        end
    endtask

    task automatic test_interleave();
        logic [1:0]  exp_ok;
        logic [31:0] exp_i, exp_d;
        for (int t = 0; t <= RD_LAT + 2; t++) begin
            step();
            case (t)
                0: drive(1'b1, 32'h4, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
                1: drive(1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 32'h8, 32'd0);
                2: drive(1'b1, 32'hC, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
                default: idle();
            endcase
            if (t < 3) begin
                n_cmp++;
                if ({bus.i_addr_ok, bus.d_addr_ok} !== {(t != 1), (t == 1)}) begin
                    n_err++;
                    $display("FAIL interleave_grant t=%0d got %b%b", t, bus.i_addr_ok, bus.d_addr_ok);
                end
            end
            exp_ok = 2'b00;
            exp_i  = 32'd0;
            exp_d  = 32'd0;
            if (t == RD_LAT)     begin exp_ok = 2'b10; exp_i = init_word(1); end
            if (t == RD_LAT + 1) begin exp_ok = 2'b01; exp_d = init_word(2); end
            if (t == RD_LAT + 2) begin exp_ok = 2'b10; exp_i = init_word(3); end
            n_cmp++;
            if ({bus.i_data_ok, bus.d_data_ok, bus.i_rdata, bus.d_rdata} !== {exp_ok, exp_i, exp_d}) begin
                n_err++;
                $display("FAIL interleave_resp t=%0d got %b%b %h %h exp %b %h %h", t, bus.i_data_ok,
                         bus.d_data_ok, bus.i_rdata, bus.d_rdata, exp_ok, exp_i, exp_d);
            end
        end
    endtask

    task automatic test_contention();
        logic exp_i;
        apply_reset();
        for (int t = 0; t < 12; t++) begin
            step();
            drive(1'b1, 32'h10, 1'b1, 1'b0, 4'd0, 32'h14, 32'd0);
            exp_i = FAIR && (t % (STARVE_MAX + 1) == STARVE_MAX);
            n_cmp++;
            if ({bus.i_addr_ok, bus.d_addr_ok} !== {exp_i, !exp_i}) begin
                n_err++;
                $display("FAIL contention t=%0d got %b%b exp %b%b", t, bus.i_addr_ok, bus.d_addr_ok,
                         exp_i, !exp_i);
            end
        end
        for (int t = 0; t < RD_LAT; t++) begin
            step();
            idle();
        end
    endtask

    task automatic test_reset_midflight();
        logic exp_i;
        apply_reset();
        for (int t = 0; t < 2; t++) begin
            step();
            drive(1'b1, 32'h10, 1'b1, 1'b0, 4'd0, 32'h14, 32'd0);
        end
        step();
        reset = 1'b1;
        drive(1'b1, 32'h10, 1'b1, 1'b0, 4'd0, 32'h14, 32'd0);
        n_cmp++;
        if (all_out !== '0) begin
            n_err++;
            $display("FAIL midflight_reset_outputs got %h exp 0", all_out);
        end
        step();
        reset = 1'b0;
        idle();
        for (int t = 0; t <= RD_LAT; t++) begin
            n_cmp++;
            if ({bus.i_data_ok, bus.d_data_ok} !== 2'b00) begin
                n_err++;
                $display("FAIL dropped_inflight t=%0d got %b%b exp 00", t, bus.i_data_ok, bus.d_data_ok);
            end
            step();
            idle();
        end
        for (int t = 0; t <= STARVE_MAX; t++) begin
            step();
            drive(1'b1, 32'h10, 1'b1, 1'b0, 4'd0, 32'h14, 32'd0);
            exp_i = FAIR && (t == STARVE_MAX);
            n_cmp++;
            if ({bus.i_addr_ok, bus.d_addr_ok} !== {exp_i, !exp_i}) begin
                n_err++;
                $display("FAIL starve_after_reset t=%0d got %b%b exp %b%b", t, bus.i_addr_ok,
                         bus.d_addr_ok, exp_i, !exp_i);
            end
        end
        for (int t = 0; t < RD_LAT; t++) begin
            step();
            idle();
        end
    endtask

    typedef struct {
        bit          fetch;
        bit          store;
        logic [31:0] data;
        int          due;
    } resp_t;

    task automatic test_random(input int n, input int p_i, input int p_d);
        resp_t       q[$];
        resp_t       r;
        bit          i_pend, d_pend, d_wr, exp_gi, exp_gd, has_r;
        logic [31:0] i_a, d_a, d_wd;
        logic [3:0]  d_st;
        int          starve;
        apply_reset();
        i_pend = 0; d_pend = 0; d_wr = 0; starve = 0;
        i_a = 0; d_a = 0; d_wd = 0; d_st = 0;
        for (int t = 0; t < n + RD_LAT + 4; t++) begin
            step();
            if (t < n && !i_pend && $urandom_range(0, 99) < p_i) begin
                i_pend = 1;
                i_a    = 32'h200 + 32'($urandom_range(0, 15)) * 4;
            end
            if (t < n && !d_pend && $urandom_range(0, 99) < p_d) begin
                d_pend = 1;
                d_wr   = $urandom_range(0, 1) == 1;
                d_st   = 4'($urandom_range(1, 15));
                d_a    = 32'h200 + 32'($urandom_range(0, 15)) * 4;
                d_wd   = $urandom;
            end
            drive(i_pend, i_a, d_pend, d_wr, d_st, d_a, d_wd);

            exp_gi = i_pend && (!d_pend || (FAIR && starve == STARVE_MAX));
            exp_gd = d_pend && !exp_gi;
            n_cmp++;
            if ({bus.i_addr_ok, bus.d_addr_ok, bus.sram_en, bus.sram_we} !==
                {exp_gi, exp_gd, exp_gi || exp_gd, (exp_gd && d_wr) ? d_st : 4'b0000}) begin
                n_err++;
                $display("FAIL rand_grant t=%0d got %b%b%b %b exp %b%b", t, bus.i_addr_ok,
                         bus.d_addr_ok, bus.sram_en, bus.sram_we, exp_gi, exp_gd);
            end
            n_cmp++;
            if ({bus.sram_addr, bus.sram_wdata} !==
                {exp_gi ? i_a : (exp_gd ? d_a : 32'd0), exp_gd ? d_wd : 32'd0}) begin
                n_err++;
                $display("FAIL rand_bus t=%0d got a=%h wd=%h", t, bus.sram_addr, bus.sram_wdata);
            end

            has_r = q.size() > 0 && q[0].due == t;
            if (has_r) r = q.pop_front();
            n_cmp++;
            if ({bus.i_data_ok, bus.d_data_ok} !== {has_r && r.fetch, has_r && !r.fetch}) begin
                n_err++;
                $display("FAIL rand_dok t=%0d got %b%b exp %b%b", t, bus.i_data_ok, bus.d_data_ok,
                         has_r && r.fetch, has_r && !r.fetch);
            end
            n_cmp++;
            if (bus.i_rdata !== ((has_r && r.fetch) ? r.data : 32'd0)) begin
                n_err++;
                $display("FAIL rand_irdata t=%0d got %h", t, bus.i_rdata);
            end
            if (!(has_r && !r.fetch && r.store)) begin
                n_cmp++;
                if (bus.d_rdata !== ((has_r && !r.fetch) ? r.data : 32'd0)) begin
                    n_err++;
                    $display("FAIL rand_drdata t=%0d got %h", t, bus.d_rdata);
                end
            end

            if (exp_gi) begin
                q.push_back('{fetch: 1'b1, store: 1'b0, data: ref_mem[i_a[9:2]], due: t + RD_LAT});
                i_pend = 0;
                starve = 0;
            end else if (exp_gd) begin
                if (i_pend && starve < STARVE_MAX) starve++;
                if (d_wr) begin
                    for (int b = 0; b < 4; b++)
                        if (d_st[b]) ref_mem[d_a[9:2]][8*b +: 8] = d_wd[8*b +: 8];
                    q.push_back('{fetch: 1'b0, store: 1'b1, data: 32'd0, due: t + RD_LAT});
                end else begin
                    q.push_back('{fetch: 1'b0, store: 1'b0, data: ref_mem[d_a[9:2]], due: t + RD_LAT});
                end
                d_pend = 0;
            end
        end
        n_cmp++;
        if (q.size() != 0 || i_pend || d_pend) begin
            n_err++;
            $display("FAIL rand_drain left=%0d pend=%b%b exp 0", q.size(), i_pend, d_pend);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_single_fetch();
        test_store_load();
        test_interleave();
        test_contention();
        test_reset_midflight();
        test_random(300, 30, 30);
        test_random(400, 90, 90);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
